// File: rtl/relu_share_arbiter_if.sv
// Handshake bundle for relu_share_arbiter: configuration write, N requester
// lanes, and the single registered result channel.
interface relu_share_arbiter_if #(
  parameter int W   = 16,
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic           cfg_val;
  logic           cfg_rdy;
  logic           cfg_bypass;
  logic [N-1:0]   req_val;
  logic [N-1:0]   req_rdy;
  logic [N*W-1:0] req_data;
  logic           out_val;
  logic           out_rdy;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           busy;

  // Drives configuration, requests and downstream ready.
  modport master (
    output cfg_val, cfg_bypass, req_val, req_data, out_rdy,
    input  cfg_rdy, req_rdy, out_val, out_data, out_id, busy
  );

  // The arbiter side.
  modport slave (
    input  cfg_val, cfg_bypass, req_val, req_data, out_rdy,
    output cfg_rdy, req_rdy, out_val, out_data, out_id, busy
  );
endinterface

// File: rtl/relu_share_arbiter.sv
// One shared ReLU/identity datapath time-multiplexed over N requesters.
// Round-robin grant in IDLE, up to BURST transfers per grant in LOCK, and a
// single output register tagged with the producing requester id.
module relu_share_arbiter #(
  parameter int W     = 16,
  parameter int N     = 4,
  parameter int BURST = 4
) (
  input  logic                clk,
  input  logic                rst,
  relu_share_arbiter_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [7:0]     r_cnt;
  logic           r_bypass;
  logic           r_out_val;
  logic [W-1:0]   r_out_data;
  logic [IDW-1:0] r_out_id;

  logic           w_any;
  logic [IDW-1:0] w_pick;
  logic [IDW:0]   w_scan;
  logic           w_slot_free;
  logic           w_xfer;
  logic           w_release;
  logic           w_last;
  logic [N-1:0]   w_req_rdy;
  logic           w_cfg_rdy;
  logic           w_busy;
  logic [W-1:0]   w_gdata;
  logic [W-1:0]   w_act;
  logic [IDW-1:0] w_ptr_inc;

  assign w_slot_free = !r_out_val || bus.out_rdy;
  assign w_last      = ({1'b0, r_cnt} + 9'd1) == 9'(BURST);
  assign w_ptr_inc   = (r_grant == IDW'(N - 1)) ? '0 : r_grant + IDW'(1);
  assign w_gdata     = bus.req_data[int'(r_grant) * W +: W];
  // Negative inputs clamp to zero unless bypass is selected.
  assign w_act       = r_bypass ? w_gdata : (w_gdata[W-1] ? '0 : w_gdata);

  // Round-robin pick: first valid requester at or after r_ptr, wrapping mod N.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    w_any  = 1'b0;
    w_pick = r_ptr;
    w_scan = '0;
    for (int i = 0; i < N; i++) begin
      w_scan = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_scan >= (IDW+1)'(N)) w_scan = w_scan - (IDW+1)'(N);
      if (!w_any && bus.req_val[w_scan[IDW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_scan[IDW-1:0];
      end
    end
  end

  // Next-state and handshake outputs of the IDLE/LOCK controller.
  always_comb begin
    w_state_next = r_state;
    w_req_rdy    = '0;
    w_cfg_rdy    = 1'b0;
    w_busy       = 1'b0;
    w_xfer       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_rdy = 1'b1;
        if (w_any) w_state_next = LOCK;
      end
      LOCK: begin
        w_busy             = 1'b1;
        w_req_rdy[r_grant] = w_slot_free;
        w_xfer             = bus.req_val[r_grant] && w_slot_free;
        w_release          = !bus.req_val[r_grant] || (w_xfer && w_last);
        if (w_release) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Arbitration bookkeeping: pointer, grant, burst count and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_grant  <= '0;
      r_cnt    <= '0;
      r_bypass <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (bus.cfg_val) r_bypass <= bus.cfg_bypass;
        if (w_any) begin
          r_grant <= w_pick;
          r_cnt   <= '0;
        end
      end
      if (w_xfer)    r_cnt <= r_cnt + 8'd1;
      if (w_release) r_ptr <= w_ptr_inc;
    end
  end

  // Output register: load on transfer, clear valid when drained without a new load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_val  <= 1'b0;
      r_out_data <= '0;
      r_out_id   <= '0;
    end else if (w_xfer) begin
      r_out_val  <= 1'b1;
      r_out_data <= w_act;
      r_out_id   <= r_grant;
    end else if (r_out_val && bus.out_rdy) begin
      r_out_val  <= 1'b0;
    end
  end

  assign bus.req_rdy  = w_req_rdy;
  assign bus.cfg_rdy  = w_cfg_rdy;
  assign bus.busy     = w_busy;
  assign bus.out_val  = r_out_val;
  assign bus.out_data = r_out_data;
  assign bus.out_id   = r_out_id;
endmodule

// File: tb/tb_relu_share_arbiter.sv
// Directed and randomized bench for relu_share_arbiter (W=16, N=4, BURST=4).
module tb_relu_share_arbiter;
  localparam int W     = 16;
  localparam int N     = 4;
  localparam int BURST = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  relu_share_arbiter_if #(.W(W), .N(N)) bus ();
  relu_share_arbiter #(.W(W), .N(N), .BURST(BURST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        byp;
    int          id;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Land 1 time unit after the rising edge: registers settled, inputs safe to change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    bus.req_data[i*W +: W] = d;
  endtask

  task automatic idle_inputs();
    bus.cfg_val    = 1'b0;
    bus.cfg_bypass = 1'b0;
    bus.req_val    = '0;
    bus.req_data   = '0;
    bus.out_rdy    = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  vec_t vecs[10];

  // Random-phase model state.
  logic        m_bypass;
  logic        m_val;
  logic [15:0] m_data;
  logic [1:0]  m_id;
  int          burst_cnt;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    do_reset();
    settle();
    check("rst_out_val",  32'(bus.out_val),  0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_out_id",   32'(bus.out_id),   0);
    check("rst_req_rdy",  32'(bus.req_rdy),  0);
    check("rst_busy",     32'(bus.busy),     0);
    check("rst_cfg_rdy",  32'(bus.cfg_rdy),  1);

    // ---------------- basic ReLU ----------------
    bus.req_val = 4'b0001;
    set_data(0, 16'h0100);
    step();                                   // IDLE arbitration
    check("basic_busy_after_grant", 32'(bus.busy), 1);
    check("basic_no_xfer_in_idle",  32'(bus.out_val), 0);
    step();
    check("basic_val1",  32'(bus.out_val),  1);
    check("basic_data1", 32'(bus.out_data), 32'h0100);
    check("basic_id1",   32'(bus.out_id),   0);
    set_data(0, 16'hFF00);
    step();
    check("basic_val2",  32'(bus.out_val),  1);
    check("basic_data2", 32'(bus.out_data), 32'h0000);
    bus.req_val = '0;
    step();
    check("basic_release_busy", 32'(bus.busy),    0);
    check("basic_drained",      32'(bus.out_val), 0);

    // ---------------- table of single-transfer bursts ----------------
    vecs[0] = '{1'b0, 0, 16'h0100, 16'h0100};
    vecs[1] = '{1'b0, 1, 16'hFF00, 16'h0000};
    vecs[2] = '{1'b0, 2, 16'h0000, 16'h0000};
    vecs[3] = '{1'b0, 3, 16'h8000, 16'h0000};
    vecs[4] = '{1'b0, 0, 16'h7FFF, 16'h7FFF};
    vecs[5] = '{1'b1, 2, 16'hFF00, 16'hFF00};
    vecs[6] = '{1'b1, 1, 16'h8000, 16'h8000};
    vecs[7] = '{1'b1, 3, 16'h0000, 16'h0000};
    vecs[8] = '{1'b0, 2, 16'h0001, 16'h0001};
    vecs[9] = '{1'b1, 0, 16'h1234, 16'h1234};
    for (int v = 0; v < 10; v++) begin
      bus.cfg_val    = 1'b1;
      bus.cfg_bypass = vecs[v].byp;
      bus.req_val    = 4'(1 << vecs[v].id);
      set_data(vecs[v].id, vecs[v].data);
      step();
      bus.cfg_val = 1'b0;
      check($sformatf("vec%0d_cfg_rdy_lock", v), 32'(bus.cfg_rdy), 0);
      step();
      check($sformatf("vec%0d_data", v), 32'(bus.out_data), 32'(vecs[v].exp));
      check($sformatf("vec%0d_id", v),   32'(bus.out_id),   32'(vecs[v].id));
      bus.req_val = '0;
      step();
      check($sformatf("vec%0d_release", v), 32'(bus.busy), 0);
    end

    // ---------------- bypass with a cfg write attempted during LOCK ----------------
    bus.cfg_val    = 1'b1;
    bus.cfg_bypass = 1'b1;
    bus.req_val    = 4'b0100;
    set_data(2, 16'hFF00);
    step();
    bus.cfg_bypass = 1'b0;                    // must be ignored in LOCK
    step();
    check("byp_data1", 32'(bus.out_data), 32'hFF00);
    check("byp_id1",   32'(bus.out_id),   2);
    set_data(2, 16'h8000);
    step();
    check("byp_data2_cfg_ignored", 32'(bus.out_data), 32'h8000);
    bus.cfg_val = 1'b0;
    bus.req_val = '0;
    step();

    // ---------------- round-robin with burst lock ----------------
    idle_inputs();
    do_reset();
    bus.req_val = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 16'(i * 16'h0100));
    for (int k = 1; k <= 22; k++) begin
      automatic int  pos  = (k - 1) % 5;
      automatic int  eid  = ((k - 1) / 5) % 4;
      automatic logic ev  = (pos != 0);
      step();
      check($sformatf("rr%0d_val", k), 32'(bus.out_val), 32'(ev));
      if (ev) begin
        check($sformatf("rr%0d_id", k),   32'(bus.out_id),   32'(eid));
        check($sformatf("rr%0d_data", k), 32'(bus.out_data), 32'(eid * 16'h0100));
      end
    end
    bus.req_val = '0;
    step();
    step();

    // ---------------- backpressure mid-burst ----------------
    idle_inputs();
    do_reset();
    bus.req_val = 4'b0001;
    set_data(0, 16'h0011);
    step();
    step();
    check("bp_first", 32'(bus.out_data), 32'h0011);
    set_data(0, 16'h0022);
    bus.out_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      settle();
      check($sformatf("bp_stall%0d_req_rdy", s), 32'(bus.req_rdy), 0);
      step();
      check($sformatf("bp_stall%0d_val", s),  32'(bus.out_val),  1);
      check($sformatf("bp_stall%0d_data", s), 32'(bus.out_data), 32'h0011);
      check($sformatf("bp_stall%0d_busy", s), 32'(bus.busy),     1);
    end
    bus.out_rdy = 1'b1;
    settle();
    check("bp_resume_req_rdy", 32'(bus.req_rdy), 32'b0001);
    step();
    check("bp_data2", 32'(bus.out_data), 32'h0022);
    set_data(0, 16'h0033);
    step();
    check("bp_data3", 32'(bus.out_data), 32'h0033);
    set_data(0, 16'h0044);
    step();
    check("bp_data4", 32'(bus.out_data), 32'h0044);
    check("bp_burst_end", 32'(bus.busy), 0);
    bus.req_val = '0;
    step();
    check("bp_no_dup", 32'(bus.out_val), 0);

    // ---------------- early release, then reset mid-burst ----------------
    idle_inputs();
    do_reset();
    bus.req_val = 4'b0010;
    set_data(1, 16'h0101);
    step();
    step();
    set_data(1, 16'h0102);
    step();
    check("early_second", 32'(bus.out_data), 32'h0102);
    bus.req_val = '0;
    step();
    check("early_release", 32'(bus.busy), 0);
    bus.req_val = 4'b1111;
    for (int i = 0; i < N; i++) set_data(i, 16'(16'h0055 + i));
    step();
    step();
    check("early_ptr2_id",  32'(bus.out_id),   2);
    check("early_ptr2_dat", 32'(bus.out_data), 32'h0057);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("midrst_out_val", 32'(bus.out_val), 0);
    check("midrst_busy",    32'(bus.busy),    0);
    check("midrst_req_rdy", 32'(bus.req_rdy), 0);
    check("midrst_cfg_rdy", 32'(bus.cfg_rdy), 1);
    step();
    step();
    check("midrst_scan0_id", 32'(bus.out_id),   0);
    check("midrst_scan0_dat", 32'(bus.out_data), 32'h0055);
    bus.req_val = '0;
    step();

    // ---------------- random traffic with output model ----------------
    idle_inputs();
    do_reset();
    m_bypass  = 1'b0;
    m_val     = 1'b0;
    m_data    = '0;
    m_id      = '0;
    burst_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      automatic logic [N-1:0] xm;
      automatic logic         nb_wr;
      automatic logic         nb_val;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 2) bus.req_val[i] = ~bus.req_val[i];
        case ($urandom_range(0, 7))
          0:       set_data(i, 16'h8000);
          1:       set_data(i, 16'h0000);
          default: set_data(i, 16'($urandom));
        endcase
      end
      bus.out_rdy    = ($urandom_range(0, 9) < 7);
      bus.cfg_val    = ($urandom_range(0, 9) == 0);
      bus.cfg_bypass = 1'($urandom);
      settle();
      check("rnd_cfg_rdy", 32'(bus.cfg_rdy), 32'(!bus.busy));
      check("rnd_rdy_shape", 32'($onehot0(bus.req_rdy) && (bus.busy || bus.req_rdy == '0)), 1);
      if (bus.req_rdy != '0) check("rnd_rdy_slot", 32'(!m_val || bus.out_rdy), 1);
      if (!bus.busy) burst_cnt = 0;
      xm     = bus.req_val & bus.req_rdy;
      nb_wr  = bus.cfg_val && bus.cfg_rdy;
      nb_val = bus.cfg_bypass;
      if (xm != '0) begin
        for (int i = 0; i < N; i++) begin
          if (xm[i]) begin
            automatic logic [15:0] d = bus.req_data[i*W +: W];
            m_data = m_bypass ? d : (d[15] ? 16'h0000 : d);
            m_id   = 2'(i);
          end
        end
        m_val = 1'b1;
        burst_cnt++;
        check("rnd_burst_bound", 32'(burst_cnt <= BURST), 1);
      end else if (m_val && bus.out_rdy) begin
        m_val = 1'b0;
      end
      if (nb_wr) m_bypass = nb_val;
      step();
      check("rnd_out_val", 32'(bus.out_val), 32'(m_val));
      if (m_val) begin
        check("rnd_out_data", 32'(bus.out_data), 32'(m_data));
        check("rnd_out_id",   32'(bus.out_id),   32'(m_id));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
